ecc_72_rd_stage: RTL and testbench

Registered read-path ECC stage for the FIFO memory: accepts raw 72-bit words with their 8-bit stored check byte from the RAM read port, decodes and corrects them with `ecc_72_top`, and presents corrected data to the FIFO output logic over a valid/ready handshake. It also keeps saturating single-bit and double-bit error counters and a first-error capture record for status/CSR readout.

---
 rtl/ecc_72_rd_stage.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_ecc_72_rd_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_72_rd_stage.sv
// ecc_72_rd_stage: registered read-path SECDED stage for the FIFO RAM.
//   S1 holds the raw word from the RAM read port, ecc_72_top decodes it
//   combinationally, and S2 holds the corrected word and its error flags.
//   Handshakes: a word moves on a port in every cycle where valid && ready
//   are both high at the rising edge; a valid word is held stable, and its
//   valid stays high, until it is taken. in_rdy depends combinationally on
//   out_rdy.
//   Optional macro ECC_ERR_LOG_EN builds the saturating sbit/dbit counters
//   and the first-error capture record; without it they read as zero.

// ecc_72_top: Hsiao-style SECDED for 72 data bits with 8 check bits.
//   Every H-matrix column has odd weight: check bit j is the unit vector,
//   data bits take weight-3/5/7 columns. Data bits 0..62 use {1, low7} with
//   low7 of even weight in ascending order (bit 0 -> 8'h83); bits 63..71 use
//   {0, low7} with low7 of odd weight >= 3 in ascending order.
//   Odd-weight syndrome -> single error; even nonzero -> uncorrectable.
module ecc_72_top (
  input  logic [71:0] data_i,
  input  logic [7:0]  parity_i,
  output logic [71:0] data_o,
  output logic [7:0]  syndrome_o,
  output logic        sbit_err_o,
  output logic        dbit_err_o
);

  function automatic logic [575:0] build_cols();
    logic [575:0] tab;
    logic [6:0]   low;
    int           n;
    tab = '0;
    n   = 0;
    for (int v = 1; v < 128; v++) begin
      low = 7'(v);
      if (n < 72 && !(^low)) begin
        tab[n*8 +: 8] = {1'b1, low};
        n++;
      end
    end
    for (int v = 1; v < 128; v++) begin
      low = 7'(v);
      if (n < 72 && (^low) && ((low & (low - 7'd1)) != 7'd0)) begin
        tab[n*8 +: 8] = {1'b0, low};
        n++;
      end
    end
    return tab;
  endfunction

  localparam logic [575:0] COLS = build_cols();

  logic [7:0] parity_gen;
  logic       data_hit;
  logic       chk_hit;

  // Recompute the check byte from the data bits.
  always_comb begin
    parity_gen = 8'h00;
    for (int i = 0; i < 72; i++) begin
      if (data_i[i]) parity_gen = parity_gen ^ COLS[i*8 +: 8];
    end
  end

  assign syndrome_o = parity_i ^ parity_gen;

  // Flip the data bit whose column matches the syndrome, if any.
  always_comb begin
    data_o   = data_i;
    data_hit = 1'b0;
    for (int i = 0; i < 72; i++) begin
      if (syndrome_o == COLS[i*8 +: 8]) begin
        data_o[i] = ~data_i[i];
        data_hit  = 1'b1;
      end
    end
  end

  // A single set syndrome bit is a flipped check bit: data needs no fix.
  assign chk_hit    = (syndrome_o != 8'h00) && ((syndrome_o & (syndrome_o - 8'h01)) == 8'h00);
  assign sbit_err_o = data_hit || chk_hit;
  assign dbit_err_o = (syndrome_o != 8'h00) && !sbit_err_o;

endmodule

module ecc_72_rd_stage #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [71:0]           in_data,
  input  logic [7:0]            in_parity,
  input  logic                  bypass,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [71:0]           out_data,
  output logic                  out_sbit_err,
  output logic                  out_dbit_err,
  input  logic                  clr,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic                  err_vld,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_dbit,
  output logic [7:0]            err_syn
);

  logic                  s1_vld_q, s1_vld_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [71:0]           s1_data_q, s1_data_d;
  logic [7:0]            s1_par_q, s1_par_d;
  logic                  s1_byp_q, s1_byp_d;
  logic                  s2_vld_q, s2_vld_d;
  logic [71:0]           s2_data_q, s2_data_d;
  logic                  s2_sbit_q, s2_sbit_d;
  logic                  s2_dbit_q, s2_dbit_d;

  logic [71:0] dec_data;
  logic [7:0]  dec_syn;
  logic        dec_sbit;
  logic        dec_dbit;
  logic        s1_load;
  logic        s2_load;

  ecc_72_top u_dec (
    .data_i     (s1_data_q),
    .parity_i   (s1_par_q),
    .data_o     (dec_data),
    .syndrome_o (dec_syn),
    .sbit_err_o (dec_sbit),
    .dbit_err_o (dec_dbit)
  );

  assign s2_load = s1_vld_q && (!s2_vld_q || out_rdy);
  assign in_rdy  = !s1_vld_q || s2_load;
  assign s1_load = in_vld && in_rdy;

  // Pipeline next state: S1 captures raw words, S2 captures decoded words.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_addr_d = s1_addr_q;
    s1_data_d = s1_data_q;
    s1_par_d  = s1_par_q;
    s1_byp_d  = s1_byp_q;
    s2_vld_d  = s2_vld_q;
    s2_data_d = s2_data_q;
    s2_sbit_d = s2_sbit_q;
    s2_dbit_d = s2_dbit_q;
    if (s1_load) begin
      s1_vld_d  = 1'b1;
      s1_addr_d = in_addr;
      s1_data_d = in_data;
      s1_par_d  = in_parity;
      s1_byp_d  = bypass;
    end else if (s2_load) begin
      s1_vld_d  = 1'b0;
    end
    if (s2_load) begin
      s2_vld_d  = 1'b1;
      s2_data_d = s1_byp_q ? s1_data_q : dec_data;
      s2_sbit_d = !s1_byp_q && dec_sbit;
      s2_dbit_d = !s1_byp_q && dec_dbit;
    end else if (out_rdy) begin
      s2_vld_d  = 1'b0;
    end
  end

  // Pipeline registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_data_q <= '0;
      s1_par_q  <= '0;
      s1_byp_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_sbit_q <= 1'b0;
      s2_dbit_q <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_addr_q <= s1_addr_d;
      s1_data_q <= s1_data_d;
      s1_par_q  <= s1_par_d;
      s1_byp_q  <= s1_byp_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      s2_sbit_q <= s2_sbit_d;
      s2_dbit_q <= s2_dbit_d;
    end
  end

  assign out_vld      = s2_vld_q;
  assign out_data     = s2_data_q;
  assign out_sbit_err = s2_sbit_q;
  assign out_dbit_err = s2_dbit_q;

`ifdef ECC_ERR_LOG_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                  ev_sbit;
  logic                  ev_dbit;
  logic [CNT_WIDTH-1:0]  sbit_cnt_q, sbit_cnt_d;
  logic [CNT_WIDTH-1:0]  dbit_cnt_q, dbit_cnt_d;
  logic                  err_vld_q, err_vld_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  err_dbit_q, err_dbit_d;
  logic [7:0]            err_syn_q, err_syn_d;

  // One error event per word, on its S1->S2 move, unless bypassed.
  assign ev_sbit = s2_load && !s1_byp_q && dec_sbit;
  assign ev_dbit = s2_load && !s1_byp_q && dec_dbit;

  // Saturating counters and first-error capture; clr beats a same-cycle event.
  always_comb begin
    sbit_cnt_d = sbit_cnt_q;
    dbit_cnt_d = dbit_cnt_q;
    err_vld_d  = err_vld_q;
    err_addr_d = err_addr_q;
    err_dbit_d = err_dbit_q;
    err_syn_d  = err_syn_q;
    if (clr) begin
      sbit_cnt_d = '0;
      dbit_cnt_d = '0;
      err_vld_d  = 1'b0;
      err_addr_d = '0;
      err_dbit_d = 1'b0;
      err_syn_d  = 8'h00;
    end else begin
      if (ev_sbit && sbit_cnt_q != '1) sbit_cnt_d = sbit_cnt_q + CNT_ONE;
      if (ev_dbit && dbit_cnt_q != '1) dbit_cnt_d = dbit_cnt_q + CNT_ONE;
      if ((ev_sbit || ev_dbit) && !err_vld_q) begin
        err_vld_d  = 1'b1;
        err_addr_d = s1_addr_q;
        err_dbit_d = ev_dbit;
        err_syn_d  = dec_syn;
      end
    end
  end

  // Error log registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbit_cnt_q <= '0;
      dbit_cnt_q <= '0;
      err_vld_q  <= 1'b0;
      err_addr_q <= '0;
      err_dbit_q <= 1'b0;
      err_syn_q  <= 8'h00;
    end else begin
      sbit_cnt_q <= sbit_cnt_d;
      dbit_cnt_q <= dbit_cnt_d;
      err_vld_q  <= err_vld_d;
      err_addr_q <= err_addr_d;
      err_dbit_q <= err_dbit_d;
      err_syn_q  <= err_syn_d;
    end
  end

  assign sbit_cnt = sbit_cnt_q;
  assign dbit_cnt = dbit_cnt_q;
  assign err_vld  = err_vld_q;
  assign err_addr = err_addr_q;
  assign err_dbit = err_dbit_q;
  assign err_syn  = err_syn_q;
`else
  // Without the log, clr, the syndrome and the carried address go nowhere.
  logic log_unused;
  assign log_unused = ^{clr, dec_syn, s1_addr_q};

  assign sbit_cnt = '0;
  assign dbit_cnt = '0;
  assign err_vld  = 1'b0;
  assign err_addr = '0;
  assign err_dbit = 1'b0;
  assign err_syn  = 8'h00;
`endif

endmodule

// File: tb/tb_ecc_72_rd_stage.sv
// Bench for ecc_72_rd_stage (CNT_WIDTH = 2): table of single-word vectors,
// then hand-written stream, backpressure, clear/saturation and reset sequences.
module tb_ecc_72_rd_stage;

`ifdef ECC_ERR_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [7:0]  in_addr = '0;
  logic [71:0] in_data = '0;
  logic [7:0]  in_parity = '0;
  logic        bypass = 1'b0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [71:0] out_data;
  logic        out_sbit_err;
  logic        out_dbit_err;
  logic        clr = 1'b0;
  logic [1:0]  sbit_cnt;
  logic [1:0]  dbit_cnt;
  logic        err_vld;
  logic [7:0]  err_addr;
  logic        err_dbit;
  logic [7:0]  err_syn;

  ecc_72_rd_stage #(.ADDR_WIDTH(8), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_addr(in_addr), .in_data(in_data),
    .in_parity(in_parity), .bypass(bypass),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_sbit_err(out_sbit_err), .out_dbit_err(out_dbit_err),
    .clr(clr), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
    .err_vld(err_vld), .err_addr(err_addr), .err_dbit(err_dbit), .err_syn(err_syn)
  );

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  logic [73:0] exp_q[$];
  int          acc_q[$];
  logic        mon_en = 1'b0;
  logic        lat_chk = 1'b0;
  logic        held_v = 1'b0;
  logic [73:0] held_w;

  always @(negedge clk) begin
    int a;
    #3;
    if (mon_en) begin
      if (held_v) check("hold_stable", {out_vld, out_data, out_sbit_err, out_dbit_err}, {1'b1, held_w});
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {out_vld, out_data}, 80'h0);
        end else begin
          check("stream_word", {out_data, out_sbit_err, out_dbit_err}, exp_q.pop_front());
          a = acc_q.pop_front();
          if (lat_chk) check("latency", cyc - a, 2);
        end
      end
      held_v = out_vld && !out_rdy;
      held_w = {out_data, out_sbit_err, out_dbit_err};
    end else begin
      held_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] a, input logic [71:0] d, input logic [7:0] p,
                      input logic b, input logic [73:0] e);
    int t;
    t = 0;
    in_vld = 1'b1; in_addr = a; in_data = d; in_parity = p; bypass = b;
    #1;
    while (!in_rdy && t < 40) begin
      step();
      t++;
    end
    if (!in_rdy) begin
      n_vec++; n_miss++;
      $display("FAIL in_rdy_timeout: got in_rdy=0 expected 1");
    end else begin
      exp_q.push_back(e);
      acc_q.push_back(cyc);
    end
    step();
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 30) begin
      step();
      t++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  addr;
    logic [71:0] data;
    logic [7:0]  par;
    logic        byp;
    logic [71:0] exp_data;
    logic        exp_s;
    logic        exp_d;
    logic [1:0]  exp_sc;
    logic [1:0]  exp_dc;
  } vec_t;

  vec_t vt[8];
  logic [71:0] top_bit;

  initial begin
    top_bit = {1'b1, 71'h0};
    //          addr   data     par    byp   exp_data s  d  sc dc
    vt[0] = '{8'h01, 72'h0,   8'h00, 1'b0, 72'h0,   0, 0, 0, 0};  // clean
    vt[1] = '{8'h2A, 72'h1,   8'h00, 1'b0, 72'h0,   1, 0, 1, 0};  // data bit 0
    vt[2] = '{8'h33, 72'h3,   8'h00, 1'b0, 72'h3,   0, 1, 1, 1};  // double
    vt[3] = '{8'h44, 72'h0,   8'h01, 1'b0, 72'h0,   1, 0, 2, 1};  // check bit 0
    vt[4] = '{8'h45, 72'h0,   8'h01, 1'b1, 72'h0,   0, 0, 2, 1};  // same, bypassed
    vt[5] = '{8'h46, 72'h3,   8'h00, 1'b1, 72'h3,   0, 0, 2, 1};  // double, bypassed
    vt[6] = '{8'h47, 72'h2,   8'h85, 1'b0, 72'h2,   0, 0, 2, 1};  // clean, bit 1 set
    vt[7] = '{8'h48, top_bit, 8'h00, 1'b0, 72'h0,   1, 0, 3, 1};  // data bit 71

    // reset state
    step(); step();
    check("rst_out_vld", out_vld, 0);
    check("rst_in_rdy", in_rdy, 1);
    check("rst_cnts", {sbit_cnt, dbit_cnt, err_vld}, 0);
    rst_n = 1'b1;
    step();

    // table: one word at a time, fixed 2-cycle latency
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_vld = 1'b1; in_addr = vt[i].addr; in_data = vt[i].data;
      in_parity = vt[i].par; bypass = vt[i].byp;
      #1;
      check("vec_in_rdy", in_rdy, 1);
      step();
      in_vld = 1'b0;
      check("vec_lat_early", out_vld, 0);
      step();
      check("vec_out_vld", out_vld, 1);
      check("vec_word", {out_data, out_sbit_err, out_dbit_err}, {vt[i].exp_data, vt[i].exp_s, vt[i].exp_d});
      check("vec_sbit_cnt", sbit_cnt, LOG ? vt[i].exp_sc : 2'd0);
      check("vec_dbit_cnt", dbit_cnt, LOG ? vt[i].exp_dc : 2'd0);
      step();
    end

    // first capture (vector 1) survives later errors
    check("cap_hold", {err_vld, err_addr, err_dbit, err_syn},
          LOG ? {1'b1, 8'h2A, 1'b0, 8'h83} : 18'h0);

    // clr zeroes the log
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_log", {sbit_cnt, dbit_cnt, err_vld, err_addr, err_dbit, err_syn}, 0);

    // double error captured first
    mon_en = 1'b1;
    send(8'h77, 72'h3, 8'h00, 1'b0, {72'h3, 1'b0, 1'b1});
    drain();
    check("cap_dbit", {dbit_cnt, err_vld, err_addr, err_dbit, err_syn},
          LOG ? {2'd1, 1'b1, 8'h77, 1'b1, 8'h06} : 20'h0);

    // clean stream of 8 back-to-back words
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) send(8'(i), 72'h0, 8'h00, 1'b0, 74'h0);
    drain();
    lat_chk = 1'b0;
    check("stream_cnts", {sbit_cnt, dbit_cnt}, LOG ? 4'b0001 : 4'b0000);

    // backpressure: two words fill the stage
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = 72'h1; in_parity = 8'h83; bypass = 1'b0;
    #1; check("bp_rdy0", in_rdy, 1);
    exp_q.push_back({72'h1, 2'b00}); acc_q.push_back(cyc);
    step();
    in_data = 72'h2; in_parity = 8'h85;
    #1; check("bp_rdy1", in_rdy, 1);
    exp_q.push_back({72'h2, 2'b00}); acc_q.push_back(cyc);
    step();
    in_data = 72'h4; in_parity = 8'h86;
    for (int k = 0; k < 4; k++) begin
      #1; check("bp_full", in_rdy, 0);
      check("bp_held", {out_vld, out_data}, {1'b1, 72'h1});
      step();
    end
    out_rdy = 1'b1;
    #1; check("bp_release_rdy", in_rdy, 1);
    exp_q.push_back({72'h4, 2'b00}); acc_q.push_back(cyc);
    step();
    in_vld = 1'b0;
    send(8'h03, 72'h8, 8'h89, 1'b0, {72'h8, 2'b00});
    send(8'h04, 72'h10, 8'h8A, 1'b0, {72'h10, 2'b00});
    drain();

    // saturation at 3, then clr coincident with a 6th error
    clr = 1'b1; step(); clr = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 72'h1, 8'h00, 1'b0, {72'h0, 2'b10});
    drain();
    check("sat_sbit", sbit_cnt, LOG ? 2'd3 : 2'd0);
    check("sat_cap", {err_vld, err_addr}, LOG ? {1'b1, 8'h10} : 9'h0);
    send(8'h20, 72'h1, 8'h00, 1'b0, {72'h0, 2'b10});
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_wins", {sbit_cnt, err_vld}, 0);
    drain();

    // asynchronous reset with two words in flight
    out_rdy = 1'b0;
    send(8'h30, 72'h1, 8'h00, 1'b0, {72'h0, 2'b10});
    send(8'h31, 72'h0, 8'h00, 1'b0, 74'h0);
    check("pre_rst_state", {out_vld, out_sbit_err, sbit_cnt},
          {1'b1, 1'b1, (LOG ? 2'd1 : 2'd0)});
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_out", {out_vld, out_data, out_sbit_err, out_dbit_err}, 0);
    check("rst_async_log", {sbit_cnt, dbit_cnt, err_vld, err_addr, err_dbit, err_syn}, 0);
    check("rst_async_rdy", in_rdy, 1);
    exp_q.delete();
    acc_q.delete();
    step();
    rst_n = 1'b1;
    out_rdy = 1'b1;
    step(); step();
    check("rst_discard", out_vld, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
